// File: rtl/acc_pkg.sv
// Shared types and arithmetic helpers for the column accumulate/drain block.
// The saturating add is only used when the build defines ACC_SAT_EN.
package acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Helpers operate at a fixed wide width; callers sign-extend a lane and keep the low DW bits.
  localparam int MAXW = 64;

  typedef struct packed {
    logic                   sat;
    logic signed [MAXW-1:0] val;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [MAXW-1:0] a,
                                       input logic signed [MAXW-1:0] b,
                                       input int                     dw);
    logic signed [MAXW-1:0] full;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    sat_res_t               r;
    full  = a + b;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    r.sat = 1'b0;
    r.val = full;
    if (full > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (full < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

  function automatic logic signed [MAXW-1:0] relu(input logic signed [MAXW-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage

// File: rtl/acc_lane_add.sv
// Single-lane combine: overwrite on the first channel, otherwise add into the buffer value.
// With ACC_SAT_EN defined the add saturates and reports it; otherwise it wraps.
module acc_lane_add
  import acc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          first,
  input  logic [DW-1:0] acc_in,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum,
  output logic          sat
);

`ifdef ACC_SAT_EN
  sat_res_t            res;
  logic                res_hi_unused;

  assign res           = sat_add(MAXW'($signed(acc_in)), MAXW'($signed(din)), DW);
  assign res_hi_unused = ^res.val[MAXW-1:DW];

  always_comb begin
    sum = first ? din : res.val[DW-1:0];
    sat = first ? 1'b0 : res.sat;
  end
`else
  always_comb begin
    sum = first ? din : acc_in + din;
    sat = 1'b0;
  end
`endif

endmodule

// File: rtl/col_acc_drain.sv
// Accumulates CIN channels of WID columns into a column buffer, then drains it in OLANES-lane beats.
// Optional ACC_SAT_EN: saturating accumulation with a sticky sat_flag.
module col_acc_drain
  import acc_pkg::*;
#(
  parameter int DW     = 32,
  parameter int LANES  = 56,
  parameter int WID    = 56,
  parameter int CIN    = 64,
  parameter int OLANES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 relu_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*DW-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OLANES*DW-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sat_flag
);

  localparam int NG  = LANES / OLANES;
  localparam int GWD = OLANES * DW;
  localparam int CW  = (WID > 1) ? $clog2(WID) : 1;
  localparam int HW  = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int GCW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0]  COL_LAST = CW'(WID - 1);
  localparam logic [HW-1:0]  CH_LAST  = HW'(CIN - 1);
  localparam logic [GCW-1:0] GRP_LAST = GCW'(NG - 1);

  if (LANES % OLANES != 0) begin : g_bad_lanes
    $error("col_acc_drain: LANES must be a multiple of OLANES");
  end

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [HW-1:0]       ch_q, ch_d;
  logic [GCW-1:0]      grp_q, grp_d;
  logic                relu_q, relu_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [GWD-1:0]      out_data_q, out_data_d;

  logic [LANES*DW-1:0] buf_q [WID];
  logic [LANES*DW-1:0] acc_col, sum_col, src_col, relu_col, drain_col;
  logic [LANES-1:0]    lane_sat;
  logic [LANES-1:0]    relu_hi_unused;
  logic [CW-1:0]       ld_col;
  logic [GCW-1:0]      ld_grp;
  logic                relu_eff, in_fire, out_fire, last_in, load;

  assign in_ready = (state_q != S_DRAIN) & ~clr;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready & ~clr;
  assign last_in  = (col_q == COL_LAST) && (ch_q == CH_LAST);
  assign acc_col  = buf_q[col_q];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    acc_lane_add #(.DW(DW)) u_add (
      .first  (ch_q == '0),
      .acc_in (acc_col[gi*DW +: DW]),
      .din    (in_data[gi*DW +: DW]),
      .sum    (sum_col[gi*DW +: DW]),
      .sat    (lane_sat[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (in_fire) buf_q[col_q] <= sum_col;
  end

  // The first drain beat is loaded on the edge that accepts the last input; with a single
  // column that column is still in flight, so it is taken straight from the adders.
  assign ld_col   = (state_q == S_DRAIN) ? col_q : '0;
  assign ld_grp   = (state_q == S_DRAIN) ? grp_q : '0;
  assign src_col  = (state_q != S_DRAIN && WID == 1) ? sum_col : buf_q[ld_col];
  assign relu_eff = (state_q == S_IDLE) ? relu_en : relu_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_relu
    logic signed [MAXW-1:0] wide;
    assign wide                 = relu(MAXW'($signed(src_col[gi*DW +: DW])));
    assign relu_col[gi*DW +: DW] = wide[DW-1:0];
    assign relu_hi_unused[gi]   = ^wide[MAXW-1:DW];
  end

  assign drain_col = relu_eff ? relu_col : src_col;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    ch_d        = ch_q;
    grp_d       = grp_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    load        = 1'b0;
    if (clr) begin
      state_d     = S_IDLE;
      col_d       = '0;
      ch_d        = '0;
      grp_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (in_fire) begin
            if (state_q == S_IDLE) relu_d = relu_en;
            if (last_in) begin
              state_d = S_DRAIN;
              ch_d    = '0;
              load    = 1'b1;
            end else begin
              state_d = S_ACCUM;
              if (col_q == COL_LAST) begin
                col_d = '0;
                ch_d  = ch_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (out_last_q) begin
              state_d     = S_IDLE;
              col_d       = '0;
              grp_d       = '0;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              load = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (load) begin
        out_valid_d = 1'b1;
        out_data_d  = drain_col[ld_grp*GWD +: GWD];
        out_last_d  = (ld_col == COL_LAST) && (ld_grp == GRP_LAST);
        if (ld_grp == GRP_LAST) begin
          grp_d = '0;
          col_d = (ld_col == COL_LAST) ? '0 : ld_col + 1'b1;
        end else begin
          grp_d = ld_grp + 1'b1;
          col_d = ld_col;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      ch_q        <= '0;
      grp_q       <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      ch_q        <= ch_d;
      grp_q       <= grp_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef ACC_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (clr) sat_d = 1'b0;
    else if (in_fire) sat_d = sat_q | (|lane_sat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  logic sat_unused;
  assign sat_unused = ^lane_sat;
  assign sat_flag   = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule
